// File: rtl/branch_predictor_bimodal.sv
// Bimodal branch predictor: 2-bit saturating BHT plus a direct-mapped, tagged BTB.
// Resolved branches update the tables through a one-stage pending register; queries answer in 1 cycle.
`timescale 1ns/1ps
module branch_predictor_bimodal #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BHT_DEPTH  = 64,
  parameter int unsigned BTB_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exbru_bp_valid,
  input  logic [ADDR_WIDTH-1:0] exbru_bp_pc,
  input  logic                  exbru_bp_jump,
  input  logic [ADDR_WIDTH-1:0] exbru_bp_next_pc,
  input  logic                  exbru_bp_hit,
  input  logic                  fetch_bp_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_bp_pc,
  output logic                  bp_fetch_valid,
  output logic                  bp_fetch_jump,
  output logic [ADDR_WIDTH-1:0] bp_fetch_next_pc,
  output logic [31:0]           bp_hit_count,
  output logic [31:0]           bp_miss_count
);

  localparam int unsigned BhtIdxW = $clog2(BHT_DEPTH);
  localparam int unsigned BtbIdxW = $clog2(BTB_DEPTH);
  localparam int unsigned TagLsb  = 2 + BtbIdxW;
  localparam int unsigned TagW    = ADDR_WIDTH - TagLsb;

  logic [1:0]            bht_q        [BHT_DEPTH];
  logic [BTB_DEPTH-1:0]  btb_valid_q;
  logic [TagW-1:0]       btb_tag_q    [BTB_DEPTH];
  logic [ADDR_WIDTH-1:0] btb_target_q [BTB_DEPTH];

  logic                  pend_valid_q;
  logic [ADDR_WIDTH-1:0] pend_pc_q;
  logic                  pend_jump_q;
  logic [ADDR_WIDTH-1:0] pend_npc_q;
  logic                  pend_hit_q;

  logic                  fetch_valid_q;
  logic                  fetch_jump_q, fetch_jump_d;
  logic [ADDR_WIDTH-1:0] fetch_npc_q, fetch_npc_d;
  logic [31:0]           hit_cnt_q, hit_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;

  logic [BhtIdxW-1:0]    upd_bht_idx, qry_bht_idx;
  logic [BtbIdxW-1:0]    upd_btb_idx, qry_btb_idx;
  logic [TagW-1:0]       upd_tag, qry_tag;
  logic [1:0]            bht_upd;
  logic                  pred_taken;

  // Byte-offset bits never reach a table index or tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pend_pc_q[1:0], fetch_bp_pc[1:0]};

  assign upd_bht_idx = pend_pc_q[2 +: BhtIdxW];
  assign upd_btb_idx = pend_pc_q[2 +: BtbIdxW];
  assign upd_tag     = pend_pc_q[ADDR_WIDTH-1:TagLsb];
  assign qry_bht_idx = fetch_bp_pc[2 +: BhtIdxW];
  assign qry_btb_idx = fetch_bp_pc[2 +: BtbIdxW];
  assign qry_tag     = fetch_bp_pc[ADDR_WIDTH-1:TagLsb];

  always_comb begin
    bht_upd = bht_q[upd_bht_idx];
    if (pend_jump_q) begin
      if (bht_q[upd_bht_idx] != 2'd3) bht_upd = bht_q[upd_bht_idx] + 2'd1;
    end else begin
      if (bht_q[upd_bht_idx] != 2'd0) bht_upd = bht_q[upd_bht_idx] - 2'd1;
    end
  end

  // Reads see the table state before this edge's write, so no write bypass.
  always_comb begin
    pred_taken   = bht_q[qry_bht_idx][1] & btb_valid_q[qry_btb_idx] &
                   (btb_tag_q[qry_btb_idx] == qry_tag);
    fetch_jump_d = fetch_jump_q;
    fetch_npc_d  = fetch_npc_q;
    if (fetch_bp_valid) begin
      fetch_jump_d = pred_taken;
      fetch_npc_d  = pred_taken ? btb_target_q[qry_btb_idx] : fetch_bp_pc + ADDR_WIDTH'(4);
    end
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (pend_valid_q) begin
      if (pend_hit_q) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q  <= 1'b0;
      pend_pc_q     <= '0;
      pend_jump_q   <= 1'b0;
      pend_npc_q    <= '0;
      pend_hit_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_jump_q  <= 1'b0;
      fetch_npc_q   <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      pend_valid_q  <= exbru_bp_valid;
      if (exbru_bp_valid) begin
        pend_pc_q   <= exbru_bp_pc;
        pend_jump_q <= exbru_bp_jump;
        pend_npc_q  <= exbru_bp_next_pc;
        pend_hit_q  <= exbru_bp_hit;
      end
      fetch_valid_q <= fetch_bp_valid;
      fetch_jump_q  <= fetch_jump_d;
      fetch_npc_q   <= fetch_npc_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
      btb_valid_q <= '0;
    end else if (pend_valid_q) begin
      bht_q[upd_bht_idx] <= bht_upd;
      if (pend_jump_q) btb_valid_q[upd_btb_idx] <= 1'b1;
    end
  end

  // Tag and target are qualified by the valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (pend_valid_q && pend_jump_q) begin
      btb_tag_q[upd_btb_idx]    <= upd_tag;
      btb_target_q[upd_btb_idx] <= pend_npc_q;
    end
  end

  assign bp_fetch_valid   = fetch_valid_q;
  assign bp_fetch_jump    = fetch_jump_q;
  assign bp_fetch_next_pc = fetch_npc_q;
  assign bp_hit_count     = hit_cnt_q;
  assign bp_miss_count    = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor_bimodal.sv
// Scoreboard bench for branch_predictor_bimodal: queries push expected predictions,
// a negedge monitor pops and compares whenever bp_fetch_valid is high.
`timescale 1ns/1ps
module tb_branch_predictor_bimodal;

  logic        clk = 1'b0;
  logic        rst;
  logic        exbru_bp_valid;
  logic [31:0] exbru_bp_pc;
  logic        exbru_bp_jump;
  logic [31:0] exbru_bp_next_pc;
  logic        exbru_bp_hit;
  logic        fetch_bp_valid;
  logic [31:0] fetch_bp_pc;
  logic        bp_fetch_valid;
  logic        bp_fetch_jump;
  logic [31:0] bp_fetch_next_pc;
  logic [31:0] bp_hit_count;
  logic [31:0] bp_miss_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        jump;
    logic [31:0] npc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  branch_predictor_bimodal dut (
    .clk              (clk),
    .rst              (rst),
    .exbru_bp_valid   (exbru_bp_valid),
    .exbru_bp_pc      (exbru_bp_pc),
    .exbru_bp_jump    (exbru_bp_jump),
    .exbru_bp_next_pc (exbru_bp_next_pc),
    .exbru_bp_hit     (exbru_bp_hit),
    .fetch_bp_valid   (fetch_bp_valid),
    .fetch_bp_pc      (fetch_bp_pc),
    .bp_fetch_valid   (bp_fetch_valid),
    .bp_fetch_jump    (bp_fetch_jump),
    .bp_fetch_next_pc (bp_fetch_next_pc),
    .bp_hit_count     (bp_hit_count),
    .bp_miss_count    (bp_miss_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented prediction must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bp_fetch_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pred: got valid=1 expected no output (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pred_jump", {31'b0, bp_fetch_jump}, {31'b0, e.jump});
        chk("pred_next_pc", bp_fetch_next_pc, e.npc);
      end
    end
  end

  // One cycle of stimulus, applied just after a negedge.
  task automatic cyc(input logic uv, input logic [31:0] upc, input logic uj,
                     input logic [31:0] unpc, input logic uh, input logic qv,
                     input logic [31:0] qpc, input logic ej, input logic [31:0] enpc);
    exp_t e;
    exbru_bp_valid   = uv;
    exbru_bp_pc      = upc;
    exbru_bp_jump    = uj;
    exbru_bp_next_pc = unpc;
    exbru_bp_hit     = uh;
    fetch_bp_valid   = qv;
    fetch_bp_pc      = qpc;
    if (qv) begin
      e.jump = ej;
      e.npc  = enpc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    exbru_bp_valid = 1'b0;
    fetch_bp_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic j, input logic [31:0] npc,
                     input logic h);
    cyc(1'b1, pc, j, npc, h, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic qry(input logic [31:0] pc, input logic ej, input logic [31:0] enpc);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, pc, ej, enpc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_counts(input logic [31:0] h, input logic [31:0] m);
    chk("hit_count", bp_hit_count, h);
    chk("miss_count", bp_miss_count, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    exbru_bp_valid = 1'b0; exbru_bp_pc = '0; exbru_bp_jump = 1'b0;
    exbru_bp_next_pc = '0; exbru_bp_hit = 1'b0;
    fetch_bp_valid = 1'b0; fetch_bp_pc = '0;
    idle(2);
    chk("rst_valid", {31'b0, bp_fetch_valid}, 32'd0);
    chk("rst_jump", {31'b0, bp_fetch_jump}, 32'd0);
    chk("rst_next_pc", bp_fetch_next_pc, 32'h0);
    chk_counts(32'd0, 32'd0);
    rst = 1'b0;
    idle(1);

    // Cold query: weakly not-taken, empty BTB.
    qry(32'h1000, 1'b0, 32'h1004);

    // Two taken updates: counter 1->3, BTB filled.
    upd(32'h1000, 1'b1, 32'h2000, 1'b0);
    upd(32'h1000, 1'b1, 32'h2000, 1'b0);
    idle(1);
    qry(32'h1000, 1'b1, 32'h2000);
    chk_counts(32'd0, 32'd2);

    // Saturate high, then step down 3->2 (still taken) and 2->1 (not taken).
    for (int i = 0; i < 5; i++) upd(32'h1000, 1'b1, 32'h2000, 1'b1);
    upd(32'h1000, 1'b0, 32'h1004, 1'b0);
    idle(1);
    qry(32'h1000, 1'b1, 32'h2000);
    upd(32'h1000, 1'b0, 32'h1004, 1'b0);
    idle(1);
    qry(32'h1000, 1'b0, 32'h1004);
    chk_counts(32'd5, 32'd4);

    // Counter back to 2; other tags at BTB index 0 must not hit.
    upd(32'h1000, 1'b1, 32'h2000, 1'b1);
    idle(1);
    qry(32'h1000, 1'b1, 32'h2000);
    qry(32'h1040, 1'b0, 32'h1044);
    qry(32'h1100, 1'b0, 32'h1104);

    // Same-cycle update and query, then a query on the write edge, then after it.
    cyc(1'b1, 32'h1008, 1'b1, 32'h3000, 1'b0, 1'b1, 32'h1008, 1'b0, 32'h100C);
    qry(32'h1008, 1'b0, 32'h100C);
    qry(32'h1008, 1'b1, 32'h3000);
    chk_counts(32'd6, 32'd5);

    // Outputs hold while no query is presented.
    idle(2);
    chk("hold_valid", {31'b0, bp_fetch_valid}, 32'd0);
    chk("hold_jump", {31'b0, bp_fetch_jump}, 32'd1);
    chk("hold_next_pc", bp_fetch_next_pc, 32'h3000);

    // Fall-through wraps at the top of the address space.
    qry(32'hFFFF_FFFC, 1'b0, 32'h0);

    // Counter floors at 0: 1->0->0, then one taken gives 1 (not taken).
    upd(32'h14, 1'b0, 32'h18, 1'b0);
    upd(32'h14, 1'b0, 32'h18, 1'b0);
    upd(32'h14, 1'b1, 32'h5000, 1'b1);
    idle(1);
    qry(32'h14, 1'b0, 32'h18);
    chk_counts(32'd7, 32'd7);

    // Hit counter saturates.
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.hit_cnt_q;
    upd(32'h20, 1'b1, 32'h6000, 1'b1);
    idle(1);
    chk_counts(32'hFFFF_FFFF, 32'd7);

    // Reset between capture and write drops the pending update.
    upd(32'h1000, 1'b1, 32'h2000, 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);
    chk_counts(32'd0, 32'd0);
    qry(32'h1000, 1'b0, 32'h1004);

    idle(2);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bimodal.md
BRANCH_PREDICTOR_BIMODAL -- requirements
Module: branch_predictor_bimodal

Interface
REQ-001 SHALL have parameter BHT_DEPTH, default 64, number of 2-bit counters, indexed by pc[7:2].
REQ-002 SHALL have parameter BTB_DEPTH, default 16, number of direct-mapped target entries, indexed by pc[5:2].
REQ-003 SHALL have port clk, input, 1, the only clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port exbru_bp_valid, input, 1, resolved-branch update strobe from the BRU.
REQ-006 SHALL have port exbru_bp_pc, input, ADDR_WIDTH, PC of the resolved branch.
REQ-007 SHALL have port exbru_bp_jump, input, 1, resolved direction, 1 = taken.
REQ-008 SHALL have port exbru_bp_next_pc, input, ADDR_WIDTH, resolved next PC.
REQ-009 SHALL have port exbru_bp_hit, input, 1, 1 = the earlier prediction matched the resolved direction.
REQ-010 SHALL have port fetch_bp_valid, input, 1, prediction query strobe.
REQ-011 SHALL have port fetch_bp_pc, input, ADDR_WIDTH, query PC.
REQ-012 SHALL have port bp_fetch_valid, output, 1, prediction result valid.
REQ-013 SHALL have port bp_fetch_jump, output, 1, predicted taken.
REQ-014 SHALL have port bp_fetch_next_pc, output, ADDR_WIDTH, predicted next PC.
REQ-015 SHALL have port bp_hit_count, output, 32, count of updates with hit=1.
REQ-016 SHALL have port bp_miss_count, output, 32, count of updates with hit=0.

Function
REQ-017 Update stage 1 SHALL register pc, jump, next_pc and hit into a pending-update register on each clk edge where exbru_bp_valid=1; the pending-valid bit follows exbru_bp_valid every cycle.
REQ-018 Update stage 2 SHALL write the tables from the pending register on the edge after capture; update-to-table latency is therefore 2 edges.
REQ-019 BHT write: if jump=1, counter = min(counter+1, 3); if jump=0, counter = max(counter-1, 0); no wrap at either end.
REQ-020 BTB write happens only when jump=1: the entry gets valid=1, tag=pc[ADDR_WIDTH-1:6] and target=next_pc; jump=0 leaves the BTB unchanged.
REQ-021 Back-to-back updates SHALL be accepted every cycle without stall, including updates to the same index, each applied in order.
REQ-022 Query latency SHALL be 1 cycle: on each edge, bp_fetch_valid <= fetch_bp_valid, and the jump and next_pc outputs are registered from the table state before that edge's update write; a same-edge write does not bypass into the query.
REQ-023 Prediction SHALL be taken when counter[1]=1, the BTB entry is valid and the tag matches.
REQ-024 When taken, next_pc SHALL be the BTB target; otherwise next_pc = fetch_bp_pc+4, truncated to ADDR_WIDTH, wrapping at the top of the address space.
REQ-025 When fetch_bp_valid=0, bp_fetch_jump and bp_fetch_next_pc SHALL hold their previous values.
REQ-026 On each stage-2 write, bp_hit_count increments if hit=1, otherwise bp_miss_count increments; both saturate at 32'hFFFFFFFF.
REQ-027 A query and an update to the same index in the same cycle SHALL both complete; the query returns the pre-update state.

Reset
REQ-028 While rst=1, all BHT counters SHALL be 2'b01, all BTB valid bits 0, pending-valid 0, bp_fetch_valid 0, bp_fetch_jump 0, bp_fetch_next_pc 0, and both counts 0, applied asynchronously.
REQ-029 Assertion of rst mid-update SHALL discard the pending update; no table write or count change follows reset release.
REQ-030 Tags and targets need no reset value; they are qualified by valid.

Verification
REQ-031 Reset, then query pc=0x1000 -> one cycle later valid=1, jump=0, next_pc=0x1004.
REQ-032 Two updates pc=0x1000, jump=1, next_pc=0x2000, hit=0, then query 0x1000 -> jump=1, next_pc=0x2000, miss_count=2.
REQ-033 Five taken updates, then two not-taken updates at 0x1000 -> counter 3 then 1; query -> jump=0, next_pc=0x1004.
REQ-034 Train 0x1000 taken, then query 0x1040 (same index, different tag) -> jump=0, next_pc=0x1044.
REQ-035 Update and query of the same pc in one cycle from counter=1 -> query returns jump=0; the next query returns jump=1 once the BTB entry is valid.
REQ-036 Force hit_count to 32'hFFFFFFFF, then apply an update with hit=1 -> value unchanged; rst pulse mid-stream -> all counts are 0 and the pending update is dropped.
